// File: rtl/lcd_copy_sequencer_if.sv
// Shared-bus signals between the framebuffer copy DMA (master) and the bus/arbiter side (slave).
interface lcd_copy_sequencer_if;
   logic        bus_req;
   logic        bus_grant;
   logic [23:0] bus_address;
   logic [7:0]  bus_data_out;
   logic        bus_write;
   logic        bus_read;
   logic [7:0]  bus_data_in;

   modport master (
      output bus_req, bus_address, bus_data_out, bus_write, bus_read,
      input  bus_grant, bus_data_in
   );

   modport slave (
      input  bus_req, bus_address, bus_data_out, bus_write, bus_read,
      output bus_grant, bus_data_in
   );
endinterface

// File: rtl/lcd_copy_sequencer.sv
// Bus-master DMA: copies a framebuffer page by page from RAM into the LCD controller,
// issuing page/column commands before each page and a read/write pair per byte.
module lcd_copy_sequencer #(
   parameter logic [23:0] FB_BASE  = 24'h001000,
   parameter int          COLUMNS  = 96,
   parameter int          PAGES    = 8,
   parameter logic [23:0] LCD_CMD  = 24'h0020FE,
   parameter logic [23:0] LCD_DATA = 24'h0020FF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_ce,
   input  logic                start,
   output logic                busy,
   output logic                done,
   lcd_copy_sequencer_if.master bus
);

   localparam logic [7:0] COL_LAST  = 8'(COLUMNS - 1);
   localparam logic [3:0] PAGE_LAST = 4'(PAGES - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_GNT, CMD_PAGE, CMD_CLO, CMD_CHI, RD, WR, DONE
   } state_t;

   state_t      state, state_n;
   logic        phase, phase_n;      // 0 = ACTIVE (strobe), 1 = GAP
   logic [3:0]  page, page_n;
   logic [7:0]  col, col_n;
   logic [7:0]  rd_byte, rd_byte_n;
   logic        in_access;
   logic [23:0] fb_addr;

   assign in_access = state inside {CMD_PAGE, CMD_CLO, CMD_CHI, RD, WR};
   assign fb_addr   = FB_BASE + (24'(page) * 24'(COLUMNS)) + 24'(col);

   always_ff @(posedge clk) begin
      if (clk_ce) begin
         if (reset) begin
            state <= IDLE;
            phase <= 1'b0;
            page  <= '0;
            col   <= '0;
         end else begin
            state <= state_n;
            phase <= phase_n;
            page  <= page_n;
            col   <= col_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clk_ce) rd_byte <= rd_byte_n;
   end

   // Without grant every access state freezes; the access resumes from its frozen phase.
   always_comb begin
      state_n   = state;
      phase_n   = phase;
      page_n    = page;
      col_n     = col;
      rd_byte_n = rd_byte;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = WAIT_GNT;
               phase_n = 1'b0;
               page_n  = '0;
               col_n   = '0;
            end
         end
         WAIT_GNT: begin
            if (bus.bus_grant) state_n = CMD_PAGE;
         end
         CMD_PAGE, CMD_CLO, CMD_CHI, RD, WR: begin
            if (bus.bus_grant) begin
               if (!phase) begin
                  phase_n = 1'b1;
                  if (state == RD) rd_byte_n = bus.bus_data_in;
               end else begin
                  phase_n = 1'b0;
                  case (state)
                     CMD_PAGE: state_n = CMD_CLO;
                     CMD_CLO:  state_n = CMD_CHI;
                     CMD_CHI:  state_n = RD;
                     RD:       state_n = WR;
                     default: begin
                        if (col < COL_LAST) begin
                           col_n   = col + 8'd1;
                           state_n = RD;
                        end else if (page < PAGE_LAST) begin
                           col_n   = '0;
                           page_n  = page + 4'd1;
                           state_n = CMD_PAGE;
                        end else begin
                           state_n = DONE;
                        end
                     end
                  endcase
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy             = (state != IDLE) && (state != DONE);
      done             = (state == DONE);
      bus.bus_req      = busy;
      bus.bus_address  = '0;
      bus.bus_data_out = '0;
      bus.bus_write    = 1'b0;
      bus.bus_read     = 1'b0;
      if (in_access && bus.bus_grant) begin
         case (state)
            RD:      bus.bus_address = fb_addr;
            WR:      bus.bus_address = LCD_DATA;
            default: bus.bus_address = LCD_CMD;
         endcase
         // Strobe and write data only in ACTIVE; the GAP keeps just the address.
         if (!phase) begin
            if (state == RD) begin
               bus.bus_read = 1'b1;
            end else begin
               bus.bus_write = 1'b1;
               case (state)
                  CMD_PAGE: bus.bus_data_out = 8'hB0 | {4'h0, page};
                  CMD_CLO:  bus.bus_data_out = 8'h00;
                  CMD_CHI:  bus.bus_data_out = 8'h10;
                  default:  bus.bus_data_out = rd_byte;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_copy_sequencer.sv
// Directed bench for lcd_copy_sequencer with a 4-column, 2-page framebuffer.
module tb_lcd_copy_sequencer;

   logic clk = 1'b0;
   logic reset, clk_ce, start;
   logic busy, done;

   lcd_copy_sequencer_if bus ();

   lcd_copy_sequencer #(
      .FB_BASE (24'h001000),
      .COLUMNS (4),
      .PAGES   (2),
      .LCD_CMD (24'h0020FE),
      .LCD_DATA(24'h0020FF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clk_ce(clk_ce),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // RAM model: byte at address A holds A[7:0] + 0x30
   assign bus.bus_data_in = bus.bus_read ? 8'(bus.bus_address[7:0] + 8'h30) : 8'h00;

   typedef struct packed {
      logic        wr;
      logic [23:0] addr;
      logic [7:0]  data;
   } acc_t;

   acc_t exp_tab [22];
   acc_t log_q [$];

   int   n_vec = 0;
   int   n_bad = 0;
   int   ce_cnt = 0;
   int   done_pulses = 0;
   int   b2b_err = 0;
   int   gl_err = 0;
   int   ce_mode = 0;
   int   ce_div = 0;
   logic prev_strobe = 1'b0;

   always @(posedge clk) if (clk_ce) ce_cnt <= ce_cnt + 1;

   always @(negedge clk) begin
      if (clk_ce) begin
         if (bus.bus_read || bus.bus_write) begin
            if (prev_strobe) b2b_err++;
            log_q.push_back(acc_t'{bus.bus_write, bus.bus_address,
                                   bus.bus_write ? bus.bus_data_out : bus.bus_data_in});
         end
         prev_strobe = bus.bus_read | bus.bus_write;
         if (done) done_pulses++;
      end
      if (!bus.bus_grant && (bus.bus_read || bus.bus_write ||
                             bus.bus_address != 24'h0 || bus.bus_data_out != 8'h0))
         gl_err++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (ce_mode != 0) begin
         ce_div = (ce_div + 1) % 3;
         clk_ce = (ce_div == 0);
      end else begin
         clk_ce = 1'b1;
      end
   endtask

   task automatic run_copy(input int drop_at, input int abort_at, input bit poke_start,
                           input string tag, input int exp_done);
      int t0, rel, c, done_rel, guard, n_at_abort;
      bit finished, aborted;
      log_q.delete();
      done_pulses = 0;
      b2b_err     = 0;
      gl_err      = 0;
      done_rel    = -1;
      finished    = 1'b0;
      aborted     = 1'b0;
      n_at_abort  = 0;

      start = 1'b1;
      guard = 0;
      while (!busy && guard < 20) begin
         step();
         guard++;
      end
      start = 1'b0;
      chk({tag, "_start_accepted"}, 64'(busy), 64'd1);
      t0 = ce_cnt;

      for (int k = 0; k < 600 && !finished && !aborted; k++) begin
         rel = ce_cnt - t0 + 1;
         if (drop_at > 0 && rel == drop_at) bus.bus_grant = 1'b0;
         if (drop_at > 0 && rel == drop_at + 2) begin
            chk({tag, "_req_held_no_grant"}, 64'(bus.bus_req), 64'd1);
            chk({tag, "_no_read_no_grant"}, 64'(bus.bus_read), 64'd0);
         end
         if (drop_at > 0 && rel == drop_at + 5) bus.bus_grant = 1'b1;
         if (poke_start && rel == 20) start = 1'b1;
         if (poke_start && rel == 22) start = 1'b0;
         if (abort_at > 0 && rel == abort_at) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk({tag, "_rst_busy"},  64'(busy),             64'd0);
            chk({tag, "_rst_done"},  64'(done),             64'd0);
            chk({tag, "_rst_req"},   64'(bus.bus_req),      64'd0);
            chk({tag, "_rst_rd"},    64'(bus.bus_read),     64'd0);
            chk({tag, "_rst_wr"},    64'(bus.bus_write),    64'd0);
            chk({tag, "_rst_addr"},  64'(bus.bus_address),  64'd0);
            chk({tag, "_rst_dout"},  64'(bus.bus_data_out), 64'd0);
            n_at_abort = log_q.size();
            aborted = 1'b1;
         end else if (done) begin
            done_rel = rel;
            c = ce_cnt;
            start = 1'b1;
            while (ce_cnt == c) step();
            start = 1'b0;
            finished = 1'b1;
         end else begin
            step();
         end
      end

      if (aborted) begin
         repeat (6) step();
         chk({tag, "_no_access_after_rst"}, 64'(log_q.size()), 64'(n_at_abort));
         chk({tag, "_idle_after_rst"}, 64'(busy), 64'd0);
      end else begin
         if (!finished) $display("FAIL %s_timeout: got no done, expected done", tag);
         chk({tag, "_done_cycle"}, 64'(done_rel), 64'(exp_done));
         repeat (6) step();
         chk({tag, "_idle_after_done"}, 64'(busy), 64'd0);
         chk({tag, "_done_pulses"}, 64'(done_pulses), 64'd1);
         chk({tag, "_access_count"}, 64'(log_q.size()), 64'd22);
         chk({tag, "_back_to_back"}, 64'(b2b_err), 64'd0);
         chk({tag, "_drive_without_grant"}, 64'(gl_err), 64'd0);
         for (int i = 0; i < 22; i++)
            chk($sformatf("%s_acc%0d", tag, i),
                (i < log_q.size()) ? 64'(log_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF,
                64'(exp_tab[i]));
      end
   endtask

   initial begin
      exp_tab = '{
         acc_t'{1'b1, 24'h0020FE, 8'hB0}, acc_t'{1'b1, 24'h0020FE, 8'h00},
         acc_t'{1'b1, 24'h0020FE, 8'h10},
         acc_t'{1'b0, 24'h001000, 8'h30}, acc_t'{1'b1, 24'h0020FF, 8'h30},
         acc_t'{1'b0, 24'h001001, 8'h31}, acc_t'{1'b1, 24'h0020FF, 8'h31},
         acc_t'{1'b0, 24'h001002, 8'h32}, acc_t'{1'b1, 24'h0020FF, 8'h32},
         acc_t'{1'b0, 24'h001003, 8'h33}, acc_t'{1'b1, 24'h0020FF, 8'h33},
         acc_t'{1'b1, 24'h0020FE, 8'hB1}, acc_t'{1'b1, 24'h0020FE, 8'h00},
         acc_t'{1'b1, 24'h0020FE, 8'h10},
         acc_t'{1'b0, 24'h001004, 8'h34}, acc_t'{1'b1, 24'h0020FF, 8'h34},
         acc_t'{1'b0, 24'h001005, 8'h35}, acc_t'{1'b1, 24'h0020FF, 8'h35},
         acc_t'{1'b0, 24'h001006, 8'h36}, acc_t'{1'b1, 24'h0020FF, 8'h36},
         acc_t'{1'b0, 24'h001007, 8'h37}, acc_t'{1'b1, 24'h0020FF, 8'h37}
      };

      reset         = 1'b1;
      start         = 1'b0;
      clk_ce        = 1'b1;
      bus.bus_grant = 1'b1;
      repeat (3) step();
      chk("reset_busy", 64'(busy),             64'd0);
      chk("reset_done", 64'(done),             64'd0);
      chk("reset_req",  64'(bus.bus_req),      64'd0);
      chk("reset_rd",   64'(bus.bus_read),     64'd0);
      chk("reset_wr",   64'(bus.bus_write),    64'd0);
      chk("reset_addr", 64'(bus.bus_address),  64'd0);
      chk("reset_dout", 64'(bus.bus_data_out), 64'd0);
      reset = 1'b0;
      step();

      // 1 + 2*(6 + 4*4) + 1 = 46 ce cycles per frame
      run_copy(0,  0,  1'b1, "base",        46);
      // grant withdrawn for 5 cycles at the page-1 column-1 read ACTIVE
      run_copy(34, 0,  1'b0, "gntloss",     51);
      run_copy(0,  20, 1'b0, "abort",       0);
      run_copy(0,  0,  1'b0, "after_abort", 46);
      ce_mode = 1;
      run_copy(0,  0,  1'b0, "ce_1in3",     46);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
